// File: rtl/pipelined_mult_unit.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
// Each of the NUM_STAGES elastic stages folds one XLEN/NUM_STAGES-bit chunk of the
// multiplier into a 2*XLEN accumulator. The last stage drives the CDB directly and
// holds its result until the arbiter grants it. A flush squashes every stage.
module pipelined_mult_unit #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  logic [1:0]       in_func,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             cdb_valid,
  output logic [XLEN-1:0]  cdb_value,
  output logic [TAG_W-1:0] cdb_tag,
  input  logic             cdb_grant
);

  localparam int CW = XLEN / NUM_STAGES;
  localparam int PW = 2 * XLEN;

  if ((NUM_STAGES < 1) || (NUM_STAGES > XLEN) || ((XLEN % NUM_STAGES) != 0)) begin : g_param_check
    $error("NUM_STAGES must divide XLEN and lie in 1..XLEN");
  end

  logic [NUM_STAGES-1:0] vld;
  logic [NUM_STAGES-1:0] adv;
  logic                  accept;

  assign accept   = in_valid && in_ready && !flush;
  assign in_ready = !vld[0] || adv[0];

  // Advance chain: last stage moves on grant, earlier stages move into a free or moving slot.
  always_comb begin
    adv = '0;
    adv[NUM_STAGES-1] = vld[NUM_STAGES-1] && cdb_grant;
    for (int s = NUM_STAGES - 2; s >= 0; s--) begin
      adv[s] = vld[s] && (!vld[s+1] || adv[s+1]);
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam bit LAST = (s == NUM_STAGES - 1);

    logic             v_q;
    logic [TAG_W-1:0] tag_q;
    logic [1:0]       func_q;
    logic [PW-1:0]    acc_q;

    logic             load;
    logic [TAG_W-1:0] src_tag;
    logic [1:0]       src_func;
    logic [PW-1:0]    src_a;
    logic [PW-1:0]    src_acc;
    logic [XLEN-1:0]  src_b;
    logic             src_neg;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_next;

    if (s == 0) begin : g_src
      // MULHU alone treats rs1 as unsigned; only MUL/MULH treat rs2 as signed.
      assign load     = accept;
      assign src_tag  = in_tag;
      assign src_func = in_func;
      assign src_a    = {{XLEN{(in_func != 2'b11) && in_opa[XLEN-1]}}, in_opa};
      assign src_b    = in_opb;
      assign src_neg  = !in_func[1] && in_opb[XLEN-1];
      assign src_acc  = '0;
    end else begin : g_src
      assign load     = adv[s-1];
      assign src_tag  = g_stage[s-1].tag_q;
      assign src_func = g_stage[s-1].func_q;
      assign src_a    = g_stage[s-1].g_tail.a_q;
      assign src_b    = g_stage[s-1].g_tail.b_q;
      assign src_neg  = g_stage[s-1].g_tail.neg_q;
      assign src_acc  = g_stage[s-1].acc_q;
    end

    assign partial = (src_a * PW'(src_b[s*CW +: CW])) << (s*CW);

    if (LAST) begin : g_tail
      // Chunks treat rs2 as unsigned; a negative signed rs2 is corrected by -A*2^XLEN.
      logic unused_src_b;
      assign unused_src_b = ^src_b;
      assign acc_next = src_acc + partial - (src_neg ? (src_a << XLEN) : '0);
    end else begin : g_tail
      logic [PW-1:0]   a_q;
      logic [XLEN-1:0] b_q;
      logic            neg_q;
      assign acc_next = src_acc + partial;

      // Operands ride along with the op until the last chunk is consumed.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_q   <= '0;
          b_q   <= '0;
          neg_q <= 1'b0;
        end else if (load) begin
          a_q   <= src_a;
          b_q   <= src_b;
          neg_q <= src_neg;
        end
      end
    end

    assign vld[s] = v_q;

    // Stage occupancy and payload; flush wins over both load and grant.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v_q    <= 1'b0;
        tag_q  <= '0;
        func_q <= '0;
        acc_q  <= '0;
      end else begin
        if (flush)       v_q <= 1'b0;
        else if (load)   v_q <= 1'b1;
        else if (adv[s]) v_q <= 1'b0;
        if (load) begin
          tag_q  <= src_tag;
          func_q <= src_func;
          acc_q  <= acc_next;
        end
      end
    end
  end

  assign cdb_valid = vld[NUM_STAGES-1];
  assign cdb_tag   = g_stage[NUM_STAGES-1].tag_q;
  assign cdb_value = (g_stage[NUM_STAGES-1].func_q == 2'b00)
                     ? g_stage[NUM_STAGES-1].acc_q[XLEN-1:0]
                     : g_stage[NUM_STAGES-1].acc_q[PW-1:XLEN];

endmodule
